// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, R-type funct
// codes, ALU-control encodings and the decoded control-word payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  // Decoded control word for one instruction
  typedef struct packed {
    logic     reg_write;
    logic     reg_dst;     // 1: write rd, 0: write rt
    logic     alu_src;     // 1: ALU b = immediate
    logic     zero_ext;    // immediate zero-extended instead of sign-extended
    logic     mem_write;
    logic     mem_to_reg;
    logic     branch_eq;
    logic     branch_ne;
    logic     jump;
    alu_ctl_e alu_ctl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    reg_dst:    1'b0,
    alu_src:    1'b0,
    zero_ext:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch_eq:  1'b0,
    branch_ne:  1'b0,
    jump:       1'b0,
    alu_ctl:    ALU_ADD
  };

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU for the MIPS subset.
//   a, b   : operands
//   ctl    : operation select (AND/OR/ADD/SUB/SLT)
//   result : combinational result, arithmetic wraps mod 2^32
//   zero   : result == 0 (used by branch compare)
module mips_alu
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_ctl_e        ctl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = XLEN'($signed(a) < $signed(b));
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS-subset processor: PC, instruction ROM, register file,
// control decode, ALU and data RAM. One instruction completes per clk.
// The instruction ROM image is supplied through the IMEM_INIT parameter
// (word i = IMEM_INIT[i]).
// Optional build macro: MIPS_EXT_INSTR_EN adds bne and ori.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low; PC held at 0 while low
//   writedata : register-file read port 2 (rt), the store data
//   dataadr   : ALU result, the data-memory byte address
//   memwrite  : current instruction is sw
module mips_single_cycle_top
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [IMEM_WORDS-1:0][31:0] IMEM_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] writedata,
  output logic [XLEN-1:0] dataadr,
  output logic            memwrite
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_next;
  logic [XLEN-1:0]    pc_plus4;
  logic [XLEN-1:0]    branch_target;
  logic [31:0]        instr;
  logic [IMEM_AW-1:0] imem_idx;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] wa;

  ctrl_t ctrl;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] simm;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            take_branch;
  logic [XLEN-1:0] wd;

  logic [XLEN-1:0]    dmem [DMEM_WORDS];
  logic [DMEM_AW-1:0] dmem_idx;
  logic [XLEN-1:0]    read_data;

  logic unused_shamt;

  // Program counter; async clear makes the first fetch after release word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end

  // Instruction fetch; PC low bits ignored, upper bits wrap over ROM depth
  assign imem_idx = pc[IMEM_AW+1:2];
  assign instr    = IMEM_INIT[imem_idx];

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  // Control decode; anything not recognised falls through to CTRL_NOP
  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctl = ALU_SUB;
          FN_AND:  ctrl.alu_ctl = ALU_AND;
          FN_OR:   ctrl.alu_ctl = ALU_OR;
          FN_SLT:  ctrl.alu_ctl = ALU_SLT;
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_ctl    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch_eq = 1'b1;
        ctrl.alu_ctl   = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
`ifdef MIPS_EXT_INSTR_EN
      OP_BNE: begin
        ctrl.branch_ne = 1'b1;
        ctrl.alu_ctl   = ALU_SUB;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_ctl   = ALU_OR;
      end
`else
`endif
      default: ctrl = CTRL_NOP;
    endcase
  end

  // Register file reads; $0 is hard-wired to zero
  assign rd1 = (rs == 5'd0) ? '0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? '0 : rf[rt];

  assign simm    = {{16{instr[15]}}, instr[15:0]};
  assign imm_ext = ctrl.zero_ext ? {16'h0000, instr[15:0]} : simm;
  assign alu_b   = ctrl.alu_src ? imm_ext : rd2;

  mips_alu u_alu (
    .a      (rd1),
    .b      (alu_b),
    .ctl    (ctrl.alu_ctl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Data RAM: combinational read, word index wraps over RAM depth
  assign dmem_idx  = alu_result[DMEM_AW+1:2];
  assign read_data = dmem[dmem_idx];

  assign wa = ctrl.reg_dst ? rd : rt;
  assign wd = ctrl.mem_to_reg ? read_data : alu_result;

  // Register file write; gated by reset level so nothing commits while held
  always_ff @(posedge clk) begin
    if (reset && ctrl.reg_write && (wa != 5'd0)) rf[wa] <= wd;
  end

  // Data RAM write
  always_ff @(posedge clk) begin
    if (reset && ctrl.mem_write) dmem[dmem_idx] <= rd2;
  end

  // Next-PC selection
  assign pc_plus4      = pc + XLEN'(4);
  assign branch_target = pc_plus4 + {simm[XLEN-3:0], 2'b00};
  assign take_branch   = (ctrl.branch_eq & alu_zero) | (ctrl.branch_ne & ~alu_zero);

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump)        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (take_branch) pc_next = branch_target;
  end

  assign writedata = rd2;
  assign dataadr   = alu_result;
  assign memwrite  = ctrl.mem_write;

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Directed bench for mips_single_cycle_top: one program image exercises
// arithmetic, load/store, branches, jump, NOP decode, address wrap and
// asynchronous reset; the bus is sampled one time unit after each falling edge.
module tb_mips_single_cycle_top;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic [31:0] dataadr;
  logic        memwrite;

  int total;
  int bad;

  function automatic logic [63:0][31:0] build_prog();
    logic [63:0][31:0] p;
    p = '0;
    p[0]  = 32'h20020226; // addi $2,$0,550
    p[1]  = 32'h20030226; // addi $3,$0,550
    p[2]  = 32'h00432022; // sub  $4,$2,$3
    p[3]  = 32'hAC040032; // sw   $4,50($0)
    p[4]  = 32'h20020007; // addi $2,$0,7
    p[5]  = 32'hAC020050; // sw   $2,80($0)
    p[6]  = 32'h8C050050; // lw   $5,80($0)
    p[7]  = 32'hAC050054; // sw   $5,84($0)
    p[8]  = 32'h2002FFFF; // addi $2,$0,-1
    p[9]  = 32'h20030001; // addi $3,$0,1
    p[10] = 32'h0043302A; // slt  $6,$2,$3
    p[11] = 32'hAC060058; // sw   $6,88($0)
    p[12] = 32'h2002000C; // addi $2,$0,12
    p[13] = 32'h2003000A; // addi $3,$0,10
    p[14] = 32'h00432024; // and  $4,$2,$3
    p[15] = 32'hAC04005C; // sw   $4,92($0)
    p[16] = 32'h00432025; // or   $4,$2,$3
    p[17] = 32'hAC040060; // sw   $4,96($0)
    p[18] = 32'h00432020; // add  $4,$2,$3
    p[19] = 32'hAC040064; // sw   $4,100($0)
    p[20] = 32'h10420001; // beq  $2,$2,+1
    p[21] = 32'h20040063; // addi $4,$0,99 (skipped)
    p[22] = 32'hAC040068; // sw   $4,104($0)
    p[23] = 32'h10430001; // beq  $2,$3,+1 (not taken)
    p[24] = 32'h20040005; // addi $4,$0,5
    p[25] = 32'hAC04006C; // sw   $4,108($0)
    p[26] = 32'h20070033; // addi $7,$0,0x33
    p[27] = 32'h340700F0; // ori  $7,$0,0xF0
    p[28] = 32'hAC070070; // sw   $7,112($0)
    p[29] = 32'h14430001; // bne  $2,$3,+1
    p[30] = 32'h2004004D; // addi $4,$0,77
    p[31] = 32'hAC040074; // sw   $4,116($0)
    p[32] = 32'hAC030105; // sw   $3,0x105($0) -> word 1
    p[33] = 32'h8C080004; // lw   $8,4($0)
    p[34] = 32'hAC080078; // sw   $8,120($0)
    p[35] = 32'hFC000000; // unknown opcode
    p[36] = 32'h0043403F; // unknown funct, rd=$8
    p[37] = 32'hAC08007C; // sw   $8,124($0)
    p[38] = 32'h20000005; // addi $0,$0,5
    p[39] = 32'hAC000080; // sw   $0,128($0)
    p[40] = 32'h0800002A; // j    42
    p[41] = 32'h20020001; // addi $2,$0,1 (skipped)
    p[42] = 32'hAC020084; // sw   $2,132($0)
    p[43] = 32'h0800002A; // j    42
    return p;
  endfunction

  localparam logic [63:0][31:0] PROG = build_prog();

`ifdef MIPS_EXT_INSTR_EN
  localparam logic [31:0] ORI_EXP = 32'h000000F0;
  localparam logic [31:0] BNE_EXP = 32'd5;
`else
  localparam logic [31:0] ORI_EXP = 32'h00000033;
  localparam logic [31:0] BNE_EXP = 32'd77;
`endif

  mips_single_cycle_top #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (64),
    .IMEM_INIT  (PROG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_sw(input string tag, input logic [31:0] adr, input logic [31:0] data);
    chk({tag, "_memwrite"}, {31'b0, memwrite}, 32'd1);
    chk({tag, "_dataadr"}, dataadr, adr);
    chk({tag, "_writedata"}, writedata, data);
  endtask

  task automatic exp_nomw(input string tag);
    chk({tag, "_memwrite"}, {31'b0, memwrite}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;

    // Held in reset: outputs follow word 0 (addi $2,$0,550)
    #12;
    exp_nomw("rst");
    chk("rst_dataadr", dataadr, 32'd550);

    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_nomw("c1");
    chk("c1_dataadr", dataadr, 32'd550);
    adv(); exp_nomw("c2");
    chk("c2_dataadr", dataadr, 32'd550);
    adv(); exp_nomw("c3");
    chk("c3_dataadr", dataadr, 32'd0);
    adv(); exp_sw("sw_sub", 32'd50, 32'd0);

    adv();
    adv(); exp_sw("sw_st7", 32'd80, 32'd7);
    adv(); exp_nomw("lw80");
    chk("lw80_dataadr", dataadr, 32'd80);
    adv(); exp_sw("sw_ld7", 32'd84, 32'd7);

    adv(); adv(); adv();
    chk("slt_dataadr", dataadr, 32'd1);
    adv(); exp_sw("sw_slt", 32'd88, 32'd1);

    adv(); adv(); adv(); adv();
    exp_sw("sw_and", 32'd92, 32'h8);
    adv(); adv();
    exp_sw("sw_or", 32'd96, 32'hE);
    adv();
    chk("add_dataadr", dataadr, 32'd22);
    adv(); exp_sw("sw_add", 32'd100, 32'd22);

    adv(); exp_nomw("beq_taken");
    adv(); exp_sw("sw_beq_skip", 32'd104, 32'd22);
    adv(); adv(); adv();
    exp_sw("sw_beq_fall", 32'd108, 32'd5);

    adv(); adv(); adv();
    exp_sw("sw_ori", 32'd112, ORI_EXP);
    adv(); exp_nomw("bne");
`ifdef MIPS_EXT_INSTR_EN
    adv();
`else
    adv(); adv();
`endif
    exp_sw("sw_bne", 32'd116, BNE_EXP);

    adv(); exp_sw("sw_wrap", 32'h105, 32'd10);
    adv(); exp_nomw("lw_wrap");
    chk("lw_wrap_dataadr", dataadr, 32'd4);
    adv(); exp_sw("sw_lw_wrap", 32'd120, 32'd10);
    adv(); exp_nomw("bad_op");
    adv(); exp_nomw("bad_funct");
    adv(); exp_sw("sw_nop_keep", 32'd124, 32'd10);
    adv(); exp_nomw("addi_r0");
    adv(); exp_sw("sw_r0", 32'd128, 32'd0);
    adv(); exp_nomw("jmp");
    adv(); exp_sw("sw_jtarget", 32'd132, 32'd12);
    adv(); exp_nomw("jmp_loop");
    adv(); exp_sw("sw_jloop", 32'd132, 32'd12);

    // Asynchronous reset between clock edges
    adv();
    #1;
    reset = 1'b0;
    #1;
    exp_nomw("arst");
    chk("arst_dataadr", dataadr, 32'd550);
    chk("arst_writedata", writedata, 32'd12);

    // A rising edge passes with reset low: addi $2 must not commit
    adv();
    chk("rst_hold_dataadr", dataadr, 32'd550);
    chk("rst_hold_writedata", writedata, 32'd12);

    reset = 1'b1;
    #1;
    exp_nomw("r2c1");
    adv(); exp_nomw("r2c2");
    adv(); exp_nomw("r2c3");
    adv(); exp_sw("sw_sub_rerun", 32'd50, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
